// File: rtl/cordic_ctrl_if.sv
// ---------------------------------------------------------------------------
// cordic_ctrl_if
//   Operand/result handshake bundle for the CORDIC controller.
//   in_valid  : producer -> controller, operand on the shared bus is valid
//   in_ready  : controller -> producer, operand accepted this cycle
//   out_valid : controller -> consumer, result registers hold a result
//   out_ready : consumer -> controller, result taken this cycle
//   Modports: master = producer/consumer side, slave = controller side.
// ---------------------------------------------------------------------------
interface cordic_ctrl_if;
    logic in_valid;
    logic in_ready;
    logic out_valid;
    logic out_ready;

    modport master (
        output in_valid,
        output out_ready,
        input  in_ready,
        input  out_valid
    );

    modport slave (
        input  in_valid,
        input  out_ready,
        output in_ready,
        output out_valid
    );
endinterface

// File: rtl/cordic_ctrl.sv
// ---------------------------------------------------------------------------
// cordic_ctrl
//   Sequencing controller for an iterative CORDIC datapath. One operation is
//   in flight at a time: load operand, N-1 micro-rotations, X result write,
//   Y result write, then hold the result until the consumer takes it.
//
//   Parameters:
//     N      number of micro-rotations per operation (N >= 2)
//   Ports:
//     clk    rising-edge clock
//     rst    synchronous, active-low reset
//     bus    handshake bundle (cordic_ctrl_if.slave)
//     busy   operation in flight (state other than IDLE)
//     c      datapath control word, bits 8:1
//              [1] operand-load select   [2] rotation-register enable
//              [5] result mux (0=X,1=Y)  [6] X result enable
//              [7] Y result enable       [8] angle-register enable
//              [3],[4] reserved, always 0
//     cnt    micro-rotation index (shift amount / angle-bit select)
//     abort  (only with CORDIC_CTRL_ABORT_EN defined) active-high abort
//
//   Optional feature macro: CORDIC_CTRL_ABORT_EN
// ---------------------------------------------------------------------------
module cordic_ctrl #(
    parameter int N = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    cordic_ctrl_if.slave         bus,
    output logic                 busy,
    output logic [8:1]           c,
    output logic [$clog2(N)-1:0] cnt
`ifdef CORDIC_CTRL_ABORT_EN
    ,
    input  logic                 abort
`endif
);
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST_ITER = CW'(N - 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ITER,
        S_OUT_X,
        S_OUT_Y,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [8:1] c_raw;
    logic       in_ready_raw;
    logic       out_valid_raw;
    logic       live;

    // Outputs are suppressed whenever the controller is being forced back
    // to IDLE, so nothing downstream sees a stale strobe during that cycle.
`ifdef CORDIC_CTRL_ABORT_EN
    assign live = rst & ~abort;
`else
    assign live = rst;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end
`ifdef CORDIC_CTRL_ABORT_EN
        else if (abort) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end
`endif
        else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        c_raw         = '0;
        in_ready_raw  = 1'b0;
        out_valid_raw = 1'b0;

        case (state_q)
            S_IDLE: begin
                in_ready_raw = 1'b1;
                cnt_d        = '0;
                // Accept term: the only output that depends on an input.
                if (bus.in_valid) begin
                    c_raw[1] = 1'b1;
                    c_raw[2] = 1'b1;
                    c_raw[8] = 1'b1;
                    state_d  = S_ITER;
                end
            end
            S_ITER: begin
                c_raw[2] = 1'b1;
                // Incrementing out of the last rotation lands exactly on
                // N-1, which is the value OUT_X/OUT_Y must present.
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST_ITER) begin
                    state_d = S_OUT_X;
                end
            end
            S_OUT_X: begin
                c_raw[6] = 1'b1;
                state_d  = S_OUT_Y;
            end
            S_OUT_Y: begin
                c_raw[5] = 1'b1;
                c_raw[7] = 1'b1;
                state_d  = S_DONE;
            end
            S_DONE: begin
                out_valid_raw = 1'b1;
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign c             = live ? c_raw : '0;
    assign bus.in_ready  = in_ready_raw & live;
    assign bus.out_valid = out_valid_raw & live;
    assign busy          = rst & (state_q != S_IDLE);
    assign cnt           = rst ? cnt_q : '0;

endmodule
